fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_rd_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the synchronous FIFO: read pointer, empty/full/level and a registered FWFT output stage.
// Optional macro FIFO_RD_OVERRUN_CHK_EN adds a sticky overrun flag for writes made while storage was full.
module fifo_rd_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DEPTH_LOG2:0]   wr_ptr,
  output logic [DEPTH_LOG2:0]   rd_ptr,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_data,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
`ifdef FIFO_RD_OVERRUN_CHK_EN
  ,
  output logic                  overrun
`endif
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_W = PW'(1 << DEPTH_LOG2);

  typedef enum logic {
    HOLD_NONE = 1'b0,
    HOLD_WORD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              pop;
  logic              consume;

  // Storage status depends only on the two registered pointers, never on dout_ready.
  always_comb begin
    empty = (wr_ptr == rd_ptr_q);
    full  = (wr_ptr[PW-1] != rd_ptr_q[PW-1]) &&
            (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    level = wr_ptr - rd_ptr_q;
  end

  // Handshake: a word transfers on an edge where dout_valid && dout_ready; ready is ignored
  // while dout_valid is low. The stage refills whenever it is empty or being drained.
  always_comb begin
    consume = (state_q == HOLD_WORD) && dout_ready;
    pop     = !empty && ((state_q == HOLD_NONE) || dout_ready);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= HOLD_NONE;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pop) begin
      state_d = HOLD_WORD;
    end else if (consume) begin
      state_d = HOLD_NONE;
    end
  end

  // Pointer wraps naturally through the PW-bit adder; the top bit separates full from empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_data;
    end
  end

  always_comb begin
    dout_valid = (state_q == HOLD_WORD);
    dout       = dout_q;
    rd_ptr     = rd_ptr_q;
    mem_addr   = rd_ptr_q[DEPTH_LOG2-1:0];
  end

`ifdef FIFO_RD_OVERRUN_CHK_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q || (level > DEPTH_W);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH_W;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a write-side model plus storage array drive the DUT, and a queue-based
// model of the FIFO contents predicts every output after each clock edge.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       clr;
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       empty;
  logic       full;
  logic [4:0] level;
`ifdef FIFO_RD_OVERRUN_CHK_EN
  logic       overrun;
`endif

  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  // Reference model: words in storage, the word held at the output, and total pops.
  logic [7:0] exp_q[$];
  bit         hv;
  logic [7:0] hw;
  int         rd_cnt;

  fifo_rd_ctrl #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .empty      (empty),
    .full       (full),
    .level      (level)
`ifdef FIFO_RD_OVERRUN_CHK_EN
    ,
    .overrun    (overrun)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write side: pointer counter and storage array
  always_ff @(posedge clk or posedge clr) begin
    if (clr) wr_ptr <= 5'd0;
    else if (wr_en) wr_ptr <= wr_ptr + 5'd1;
  end

  always @(posedge clk) begin
    if (!clr && wr_en) mem[wr_ptr[3:0]] <= wr_data;
  end

  assign mem_data = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, hv});
    chk("dout",       {24'd0, dout},       {24'd0, hw});
    chk("rd_ptr",     {27'd0, rd_ptr},     rd_cnt);
    chk("mem_addr",   {28'd0, mem_addr},   rd_cnt % 16);
    chk("empty",      {31'd0, empty},      (exp_q.size() == 0) ? 1 : 0);
    chk("full",       {31'd0, full},       (exp_q.size() == 16) ? 1 : 0);
    chk("level",      {27'd0, level},      exp_q.size());
  endtask

  task automatic model_reset();
    exp_q.delete();
    hv     = 1'b0;
    hw     = 8'h00;
    rd_cnt = 0;
  endtask

  // Driver: apply one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input bit we, input logic [7:0] d, input bit rdy);
    bit do_pop;
    wr_en      = we;
    wr_data    = d;
    dout_ready = rdy;
    @(posedge clk);
    do_pop = (exp_q.size() > 0) && (!hv || rdy);
    if (do_pop) begin
      hw     = exp_q.pop_front();
      hv     = 1'b1;
      rd_cnt = (rd_cnt + 1) % 32;
    end else if (hv && rdy) begin
      hv = 1'b0;
    end
    if (we) exp_q.push_back(d);
    #1;
  endtask

  initial begin
    bit         saw_wrap;
    logic [4:0] prev_rd;
    bit         we;

    clr        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    dout_ready = 1'b0;
    model_reset();
    #12;
    chk_all();
    @(negedge clk);
    clr = 1'b0;

    // Single word with consumer stalled
    step(1'b1, 8'hA5, 1'b0); chk_all();
    step(1'b0, 8'h00, 1'b0); chk_all();
    chk("single_dout", {24'd0, dout}, 32'hA5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0); chk_all();
    end
    step(1'b0, 8'h00, 1'b1); chk_all();

    // Fill to 16 stored + 1 held, then drain continuously
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0); chk_all();
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 8'h00, 1'b1); chk_all();
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Streaming through the pointer wrap
    saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_rd = rd_ptr;
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1); chk_all();
      if (prev_rd == 5'd31 && rd_ptr == 5'd0) saw_wrap = 1'b1;
    end
    chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1); chk_all();
    end

    // Backpressure: alternating ready, writes every other cycle
    for (int i = 0; i < 24; i++) begin
      step((i % 2) == 0, 8'($urandom_range(0, 255)), (i % 2) == 1); chk_all();
    end

    // Random traffic, writer respects full
    for (int i = 0; i < 120; i++) begin
      we = ($urandom_range(0, 3) != 0) && (exp_q.size() < 16);
      step(we, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0); chk_all();
    end

    // Asynchronous clear mid-burst with level 5 and a held word
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 8'h00, 1'b1);
    end
    chk_all();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0);
    end
    chk_all();
    chk("pre_clr_level", {27'd0, level}, 32'd5);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("clr_rd_ptr",     {27'd0, rd_ptr},     32'd0);
    chk("clr_dout",       {24'd0, dout},       32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    step(1'b0, 8'h00, 1'b1); chk_all();
    step(1'b1, 8'h77, 1'b0); chk_all();
    step(1'b0, 8'h00, 1'b0); chk_all();

`ifdef FIFO_RD_OVERRUN_CHK_EN
    // Overrun: write while storage holds 16 words
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
    end
    chk("ovr_full", {31'd0, full}, 32'd1);
    chk("ovr_not_yet", {31'd0, overrun}, 32'd0);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovr_level17", {27'd0, level}, 32'd17);
    step(1'b0, 8'h00, 1'b0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    #3;
    clr = 1'b1;
    #1;
    chk("overrun_clr", {31'd0, overrun}, 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
